// File: rtl/riscv_ctrl_pipe.sv
// Control-path pipeline for the RV32I core: per-stage control/valid from ID through EX..WB,
// with bubble/flush/stall handling, load-use hazard detection and forwarding-source selection.
module riscv_ctrl_pipe #(
    parameter int unsigned NUM_STAGES    = 3,
    parameter int unsigned CTRL_W        = 24,
    parameter int unsigned LOAD_USE_DIST = 1,
    localparam int unsigned SEL_W        = $clog2(NUM_STAGES + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_id_valid,
    input  logic                         i_id_rd_wren,
    input  logic [4:0]                   i_id_rd_addr,
    input  logic [4:0]                   i_id_rs1_addr,
    input  logic [4:0]                   i_id_rs2_addr,
    input  logic                         i_id_rs1_used,
    input  logic                         i_id_rs2_used,
    input  logic                         i_id_mem_load,
    input  logic [CTRL_W-1:0]            i_id_ctrl,
    input  logic                         i_flush,
    input  logic                         i_stall_ext,
    output logic                         o_stall_id,
    output logic [NUM_STAGES-1:0]        o_stg_valid,
    output logic [NUM_STAGES-1:0]        o_stg_rd_wren,
    output logic [5*NUM_STAGES-1:0]      o_stg_rd_addr,
    output logic [NUM_STAGES-1:0]        o_stg_mem_load,
    output logic [CTRL_W*NUM_STAGES-1:0] o_stg_ctrl,
    output logic [SEL_W-1:0]             o_fwd_rs1_sel,
    output logic [SEL_W-1:0]             o_fwd_rs2_sel,
    output logic [31:0]                  o_retire_cnt
);

    localparam int unsigned RD_W = 5;

    logic [NUM_STAGES-1:0]        valid_q, valid_d;
    logic [NUM_STAGES-1:0]        wren_q, wren_d;
    logic [NUM_STAGES-1:0]        load_q, load_d;
    logic [RD_W*NUM_STAGES-1:0]   rd_q, rd_d;
    logic [CTRL_W*NUM_STAGES-1:0] ctrl_q, ctrl_d;
    logic [31:0]                  cnt_q, cnt_d;

    logic                         found1, found2;
    logic                         near_ld1, near_ld2;
    logic [SEL_W-1:0]             sel1, sel2;
    logic                         hazard_c;
    logic                         take_id;

    // Youngest matching producer per operand; a too-close load blocks forwarding.
    always_comb begin
        found1   = 1'b0;
        found2   = 1'b0;
        near_ld1 = 1'b0;
        near_ld2 = 1'b0;
        sel1     = '0;
        sel2     = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (!found1 && valid_q[k] && wren_q[k] && i_id_rs1_used &&
                (i_id_rs1_addr != 5'd0) && (rd_q[RD_W*k +: RD_W] == i_id_rs1_addr)) begin
                found1   = 1'b1;
                sel1     = SEL_W'(k + 1);
                near_ld1 = load_q[k] && (k < LOAD_USE_DIST);
            end
            if (!found2 && valid_q[k] && wren_q[k] && i_id_rs2_used &&
                (i_id_rs2_addr != 5'd0) && (rd_q[RD_W*k +: RD_W] == i_id_rs2_addr)) begin
                found2   = 1'b1;
                sel2     = SEL_W'(k + 1);
                near_ld2 = load_q[k] && (k < LOAD_USE_DIST);
            end
        end
    end

    assign hazard_c      = i_id_valid & (near_ld1 | near_ld2);
    assign o_stall_id    = hazard_c & ~i_flush;
    assign o_fwd_rs1_sel = near_ld1 ? '0 : sel1;
    assign o_fwd_rs2_sel = near_ld2 ? '0 : sel2;
    assign take_id       = i_id_valid & ~i_flush & ~hazard_c;

    // Next state: shift when running, hold when frozen (flush still kills stage 0).
    always_comb begin
        valid_d = valid_q;
        wren_d  = wren_q;
        load_d  = load_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (!i_stall_ext) begin
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                valid_d[k]                 = valid_q[k-1];
                wren_d[k]                  = wren_q[k-1];
                load_d[k]                  = load_q[k-1];
                rd_d[RD_W*k +: RD_W]       = rd_q[RD_W*(k-1) +: RD_W];
                ctrl_d[CTRL_W*k +: CTRL_W] = ctrl_q[CTRL_W*(k-1) +: CTRL_W];
            end
            cnt_d = cnt_q + 32'(valid_q[NUM_STAGES-1]);
            if (take_id) begin
                valid_d[0]          = 1'b1;
                wren_d[0]           = i_id_rd_wren;
                load_d[0]           = i_id_mem_load;
                rd_d[0 +: RD_W]     = i_id_rd_addr;
                ctrl_d[0 +: CTRL_W] = i_id_ctrl;
            end else begin
                valid_d[0]          = 1'b0;
                wren_d[0]           = 1'b0;
                load_d[0]           = 1'b0;
                rd_d[0 +: RD_W]     = '0;
                ctrl_d[0 +: CTRL_W] = '0;
            end
        end else if (i_flush) begin
            valid_d[0]          = 1'b0;
            wren_d[0]           = 1'b0;
            load_d[0]           = 1'b0;
            rd_d[0 +: RD_W]     = '0;
            ctrl_d[0 +: CTRL_W] = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            wren_q  <= '0;
            load_q  <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wren_q  <= wren_d;
            load_q  <= load_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_stg_valid    = valid_q;
    assign o_stg_rd_wren  = wren_q;
    assign o_stg_rd_addr  = rd_q;
    assign o_stg_mem_load = load_q;
    assign o_stg_ctrl     = ctrl_q;
    assign o_retire_cnt   = cnt_q;

endmodule

// File: tb/tb_riscv_ctrl_pipe.sv
// Scoreboard bench for riscv_ctrl_pipe: directed cycles push expected outputs, a negedge monitor checks them.
module tb_riscv_ctrl_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        wren;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        ld;
        logic [23:0] ctrl;
        logic        flush;
        logic        stall;
    } stim_t;

    typedef struct {
        string       name;
        logic        stall;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [2:0]  valid;
        logic [31:0] cnt;
        logic [23:0] ctrl_last;
    } exp_t;

    stim_t a, b;
    exp_t  q1[$];
    exp_t  q2[$];
    int    n_cmp = 0;
    int    n_err = 0;

    logic        a_stall, b_stall;
    logic [2:0]  a_valid, a_wren, a_load, b_valid, b_wren, b_load;
    logic [14:0] a_rd, b_rd;
    logic [71:0] a_ctrl, b_ctrl;
    logic [1:0]  a_f1, a_f2, b_f1, b_f2;
    logic [31:0] a_cnt, b_cnt;

    riscv_ctrl_pipe #(.NUM_STAGES(3), .CTRL_W(24), .LOAD_USE_DIST(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_valid(a.v), .i_id_rd_wren(a.wren), .i_id_rd_addr(a.rd),
        .i_id_rs1_addr(a.rs1), .i_id_rs2_addr(a.rs2),
        .i_id_rs1_used(a.u1), .i_id_rs2_used(a.u2),
        .i_id_mem_load(a.ld), .i_id_ctrl(a.ctrl),
        .i_flush(a.flush), .i_stall_ext(a.stall),
        .o_stall_id(a_stall), .o_stg_valid(a_valid), .o_stg_rd_wren(a_wren),
        .o_stg_rd_addr(a_rd), .o_stg_mem_load(a_load), .o_stg_ctrl(a_ctrl),
        .o_fwd_rs1_sel(a_f1), .o_fwd_rs2_sel(a_f2), .o_retire_cnt(a_cnt)
    );

    riscv_ctrl_pipe #(.NUM_STAGES(3), .CTRL_W(24), .LOAD_USE_DIST(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_valid(b.v), .i_id_rd_wren(b.wren), .i_id_rd_addr(b.rd),
        .i_id_rs1_addr(b.rs1), .i_id_rs2_addr(b.rs2),
        .i_id_rs1_used(b.u1), .i_id_rs2_used(b.u2),
        .i_id_mem_load(b.ld), .i_id_ctrl(b.ctrl),
        .i_flush(b.flush), .i_stall_ext(b.stall),
        .o_stall_id(b_stall), .o_stg_valid(b_valid), .o_stg_rd_wren(b_wren),
        .o_stg_rd_addr(b_rd), .o_stg_mem_load(b_load), .o_stg_ctrl(b_ctrl),
        .o_fwd_rs1_sel(b_f1), .o_fwd_rs2_sel(b_f2), .o_retire_cnt(b_cnt)
    );

    function automatic stim_t s_idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t s_wr(logic [4:0] rd, logic [23:0] c, logic ld);
        stim_t s;
        s      = '0;
        s.v    = 1'b1;
        s.wren = 1'b1;
        s.rd   = rd;
        s.ctrl = c;
        s.ld   = ld;
        return s;
    endfunction

    function automatic exp_t ex(string n, logic st, logic [1:0] f1, logic [1:0] f2,
                                logic [2:0] v, logic [31:0] cnt, logic [23:0] cl);
        exp_t e;
        e.name = n; e.stall = st; e.f1 = f1; e.f2 = f2;
        e.valid = v; e.cnt = cnt; e.ctrl_last = cl;
        return e;
    endfunction

    task automatic cyc1(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        a = s;
        q1.push_back(e);
    endtask

    task automatic cyc2(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        b = s;
        q2.push_back(e);
    endtask

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", n, f, act, exp);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared against the live outputs.
    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk(e.name, "stall", 32'(a_stall), 32'(e.stall));
            chk(e.name, "fwd1", 32'(a_f1), 32'(e.f1));
            chk(e.name, "fwd2", 32'(a_f2), 32'(e.f2));
            chk(e.name, "valid", 32'(a_valid), 32'(e.valid));
            chk(e.name, "cnt", a_cnt, e.cnt);
            chk(e.name, "ctrl_last", 32'(a_ctrl[71:48]), 32'(e.ctrl_last));
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            chk(e.name, "stall", 32'(b_stall), 32'(e.stall));
            chk(e.name, "fwd1", 32'(b_f1), 32'(e.f1));
            chk(e.name, "valid", 32'(b_valid), 32'(e.valid));
            chk(e.name, "cnt", b_cnt, e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        int    guard;
        rst_n = 1'b0;
        a = s_idle();
        b = s_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc1(s_idle(), ex("reset", 0, 0, 0, 3'b000, 0, 0));

        // fill three stages, then async reset mid-cycle
        cyc1(s_wr(1, 24'h11, 0), ex("fill0", 0, 0, 0, 3'b000, 0, 0));
        cyc1(s_wr(2, 24'h22, 0), ex("fill1", 0, 0, 0, 3'b001, 0, 0));
        cyc1(s_wr(3, 24'h33, 0), ex("fill2", 0, 0, 0, 3'b011, 0, 0));
        cyc1(s_idle(), ex("fill3", 0, 0, 0, 3'b111, 0, 24'h11));
        @(posedge clk);
        #1 rst_n = 1'b0;
        q1.push_back(ex("mid_rst", 0, 0, 0, 3'b000, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        q1.push_back(ex("post_rst", 0, 0, 0, 3'b000, 0, 0));

        // load-use: lw x5 then add x6,x5
        cyc1(s_wr(5, 24'h55, 1), ex("lu_lw", 0, 0, 0, 3'b000, 0, 0));
        s = s_wr(6, 24'h66, 0); s.rs1 = 5; s.u1 = 1'b1;
        cyc1(s, ex("lu_stall", 1, 0, 0, 3'b001, 0, 0));
        cyc1(s, ex("lu_fwd", 0, 2, 0, 3'b010, 0, 0));
        cyc1(s_idle(), ex("lu_d0", 0, 0, 0, 3'b101, 0, 24'h55));
        cyc1(s_idle(), ex("lu_d1", 0, 0, 0, 3'b010, 1, 0));
        cyc1(s_idle(), ex("lu_d2", 0, 0, 0, 3'b100, 1, 24'h66));
        cyc1(s_idle(), ex("lu_d3", 0, 0, 0, 3'b000, 2, 0));

        // priority: two writers of x7, frozen with stall_ext while probing
        cyc1(s_wr(7, 24'h71, 0), ex("pr_w0", 0, 0, 0, 3'b000, 2, 0));
        cyc1(s_wr(7, 24'h72, 0), ex("pr_w1", 0, 0, 0, 3'b001, 2, 0));
        s = s_wr(8, 24'h80, 0); s.rs2 = 7; s.u2 = 1'b1; s.stall = 1'b1;
        cyc1(s, ex("prio", 0, 0, 1, 3'b011, 2, 0));
        s.u2 = 1'b0; s.rs1 = 7; s.u1 = 1'b1;
        cyc1(s, ex("prio_unused", 0, 1, 0, 3'b011, 2, 0));
        cyc1(s_idle(), ex("pr_hold", 0, 0, 0, 3'b011, 2, 0));
        cyc1(s_idle(), ex("pr_d0", 0, 0, 0, 3'b110, 2, 24'h71));
        cyc1(s_idle(), ex("pr_d1", 0, 0, 0, 3'b100, 3, 24'h72));
        cyc1(s_idle(), ex("pr_d2", 0, 0, 0, 3'b000, 4, 0));

        // x0 destination never forwards nor stalls
        cyc1(s_wr(0, 24'h0A, 1), ex("x0_lw", 0, 0, 0, 3'b000, 4, 0));
        s = s_wr(9, 24'h09, 0); s.rs1 = 0; s.u1 = 1'b1;
        cyc1(s, ex("x0_use", 0, 0, 0, 3'b001, 4, 0));
        cyc1(s_idle(), ex("x0_d0", 0, 0, 0, 3'b011, 4, 0));
        cyc1(s_idle(), ex("x0_d1", 0, 0, 0, 3'b110, 4, 24'h0A));
        cyc1(s_idle(), ex("x0_d2", 0, 0, 0, 3'b100, 5, 24'h09));
        cyc1(s_idle(), ex("x0_d3", 0, 0, 0, 3'b000, 6, 0));

        // flush together with load-use
        cyc1(s_wr(5, 24'h55, 1), ex("fl_lw", 0, 0, 0, 3'b000, 6, 0));
        s = s_wr(6, 24'h66, 0); s.rs1 = 5; s.u1 = 1'b1; s.flush = 1'b1;
        cyc1(s, ex("fl_haz", 0, 0, 0, 3'b001, 6, 0));
        cyc1(s_idle(), ex("fl_bubble", 0, 0, 0, 3'b010, 6, 0));

        // external stall for 3 edges with last stage valid
        s = s_idle(); s.stall = 1'b1;
        cyc1(s, ex("st_enter", 0, 0, 0, 3'b100, 6, 24'h55));
        cyc1(s, ex("st_hold1", 0, 0, 0, 3'b100, 6, 24'h55));
        cyc1(s, ex("st_hold2", 0, 0, 0, 3'b100, 6, 24'h55));
        cyc1(s_idle(), ex("st_hold3", 0, 0, 0, 3'b100, 6, 24'h55));
        cyc1(s_idle(), ex("st_release", 0, 0, 0, 3'b000, 7, 0));

        // LOAD_USE_DIST=2: load in stage 1 still stalls, forwards from stage 2
        cyc2(s_wr(5, 24'h55, 1), ex("d2_lw", 0, 0, 0, 3'b000, 0, 0));
        cyc2(s_idle(), ex("d2_gap", 0, 0, 0, 3'b001, 0, 0));
        s = s_wr(6, 24'h66, 0); s.rs1 = 5; s.u1 = 1'b1;
        cyc2(s, ex("d2_stall", 1, 0, 0, 3'b010, 0, 0));
        cyc2(s, ex("d2_fwd", 0, 3, 0, 3'b100, 0, 0));
        cyc2(s_idle(), ex("d2_issue", 0, 0, 0, 3'b001, 1, 0));

        guard = 0;
        while ((q1.size() > 0 || q2.size() > 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q1.size() > 0 || q2.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q1.size() + q2.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
